// File: rtl/ram_wb_arbiter_if.sv
// rtl/ram_wb_arbiter_if.sv - Wishbone bundle for the pattern RAM arbiter's master and slave ports
interface ram_wb_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;
  logic              err;

  // err only flows back towards an upstream master, so the initiator view leaves it out
  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/ram_wb_arbiter.sv
// rtl/ram_wb_arbiter.sv - round-robin two-master Wishbone arbiter for the pattern RAM
// Optional grant timeout with ABORT state enabled by ARB_TIMEOUT_EN.
module ram_wb_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  ram_wb_arbiter_if.slave  m0,
  ram_wb_arbiter_if.slave  m1,
  ram_wb_arbiter_if.master s,
  output logic [1:0]       grant_o
);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
`else
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
`endif

  state_t            state;
  state_t            state_n;
  logic              last_grant;
  logic              last_grant_n;
  logic              req0;
  logic              req1;
  logic              own0;
  logic              own1;
  logic [ADDR_W-1:0] adr_mux;
  logic [DATA_W-1:0] dat_mux;

  assign req0 = m0.cyc & m0.stb;
  assign req1 = m1.cyc & m1.stb;
  assign own0 = (state == GNT0);
  assign own1 = (state == GNT1);

`ifdef ARB_TIMEOUT_EN
  logic             timeout_hit;
  logic [CNT_W-1:0] wait_cnt;

  // Counts grant cycles already spent without an ack; zero in the first grant cycle
  always_ff @(posedge clk) begin
    if (reset || !(own0 || own1) || s.ack) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (own0 | own1) & ~s.ack & (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign m0.err      = own0 & timeout_hit;
  assign m1.err      = own1 & timeout_hit;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign m0.err         = 1'b0;
  assign m1.err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    case (state)
      IDLE: begin
        // On contention the master that did not hold the previous grant wins
        if (req0 && (!req1 || last_grant)) begin
          state_n      = GNT0;
          last_grant_n = 1'b0;
        end else if (req1) begin
          state_n      = GNT1;
          last_grant_n = 1'b1;
        end
      end
      GNT0: begin
        if (!m0.cyc) begin
          state_n = IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_n = ABORT;
`endif
        end
      end
      GNT1: begin
        if (!m1.cyc) begin
          state_n = IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_n = ABORT;
`endif
        end
      end
`ifdef ARB_TIMEOUT_EN
      ABORT: begin
        // last_grant still names the aborted master; wait for it to release the bus
        if (last_grant ? !m1.cyc : !m0.cyc) begin
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign adr_mux = own0 ? m0.adr   : (own1 ? m1.adr   : '0);
  assign dat_mux = own0 ? m0.dat_w : (own1 ? m1.dat_w : '0);

  assign s.cyc   = own0 ? m0.cyc : (own1 ? m1.cyc : 1'b0);
  assign s.stb   = own0 ? m0.stb : (own1 ? m1.stb : 1'b0);
  assign s.we    = own0 ? m0.we  : (own1 ? m1.we  : 1'b0);
  assign s.sel   = own0 ? m0.sel : (own1 ? m1.sel : 4'b0000);
  assign s.adr   = adr_mux;
  assign s.dat_w = dat_mux;

  assign m0.ack   = own0 & s.ack;
  assign m1.ack   = own1 & s.ack;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign grant_o  = {own1, own0};

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// tb/tb_ram_wb_arbiter.sv - self-checking bench for ram_wb_arbiter
`timescale 1ns/1ps
module tb_ram_wb_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] grant;
  always #5 clk = ~clk;

  ram_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  ram_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  ram_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  ram_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus), .s(s_bus), .grant_o(grant)
  );

  logic [1:0]        mc, ms, mw;
  logic [3:0]        msel [2];
  logic [ADDR_W-1:0] madr [2];
  logic [DATA_W-1:0] mdat [2];
  logic              s_ack;
  logic [DATA_W-1:0] s_rdata;

  assign m0_bus.cyc = mc[0];   assign m1_bus.cyc = mc[1];
  assign m0_bus.stb = ms[0];   assign m1_bus.stb = ms[1];
  assign m0_bus.we  = mw[0];   assign m1_bus.we  = mw[1];
  assign m0_bus.sel = msel[0]; assign m1_bus.sel = msel[1];
  assign m0_bus.adr = madr[0]; assign m1_bus.adr = madr[1];
  assign m0_bus.dat_w = mdat[0]; assign m1_bus.dat_w = mdat[1];
  assign s_bus.ack = s_ack;
  assign s_bus.dat_r = s_rdata;
  assign s_bus.err = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    mc = 2'b00; ms = 2'b00; mw = 2'b00; s_ack = 1'b0; s_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      msel[k] = 4'h0; madr[k] = '0; mdat[k] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_masters();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_masters();
    mc = 2'b11; ms = 2'b11; s_ack = 1'b1; madr[0] = 8'h44; msel[0] = 4'hF;
    step();
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0 || s_bus.we !== 1'b0) begin errors++; $display("FAIL reset_sctl got %b%b%b exp 000", s_bus.cyc, s_bus.stb, s_bus.we); end
    checks++; if (s_bus.sel !== 4'h0 || s_bus.adr !== '0) begin errors++; $display("FAIL reset_saddr got sel %h adr %h exp 0 0", s_bus.sel, s_bus.adr); end
    checks++; if (m0_bus.ack !== 1'b0 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b%b exp 00", m1_bus.ack, m0_bus.ack); end
    checks++; if (m0_bus.err !== 1'b0 || m1_bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", m1_bus.err, m0_bus.err); end
    idle_masters();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    do_reset();
    mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b1; madr[0] = 8'h03; mdat[0] = 32'hA5A5A5A5; msel[0] = 4'hF;
    @(negedge clk);
    checks++; if (s_bus.stb !== 1'b0) begin errors++; $display("FAIL write_latency got stb %b exp 0", s_bus.stb); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL write_grant got %b exp 01", grant); end
    checks++; if (s_bus.stb !== 1'b1 || s_bus.we !== 1'b1 || s_bus.adr !== 8'h03) begin errors++; $display("FAIL write_ctl got stb %b we %b adr %h exp 1 1 03", s_bus.stb, s_bus.we, s_bus.adr); end
    checks++; if (s_bus.dat_w !== 32'hA5A5A5A5 || s_bus.sel !== 4'hF) begin errors++; $display("FAIL write_data got %h sel %h exp a5a5a5a5 f", s_bus.dat_w, s_bus.sel); end
    s_ack = 1'b1;
    #1;
    checks++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL write_ack got m0 %b m1 %b exp 1 0", m0_bus.ack, m1_bus.ack); end
    step();
    mc[0] = 1'b0; ms[0] = 1'b0; s_ack = 1'b0;
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL write_release got %b exp 00", grant); end
  endtask

  task automatic test_contention();
    do_reset();
    mc = 2'b11; ms = 2'b11; mw = 2'b01; madr[0] = 8'h05; mdat[0] = $urandom; madr[1] = 8'h00; msel[1] = 4'hF;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_latency got %b exp 00", grant); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_first got %b exp 01", grant); end
    s_ack = 1'b1;
    step();
    mc[0] = 1'b0; ms[0] = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL cont_drop_cyc got %b exp 0", s_bus.cyc); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b00 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL cont_idle got grant %b cyc %b exp 00 0", grant, s_bus.cyc); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b10 || s_bus.adr !== 8'h00 || s_bus.we !== 1'b0) begin errors++; $display("FAIL cont_second got grant %b adr %h we %b exp 10 00 0", grant, s_bus.adr, s_bus.we); end
    s_rdata = 32'h11223344; s_ack = 1'b1;
    #1;
    checks++; if (m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0) begin errors++; $display("FAIL cont_ack got m1 %b m0 %b exp 1 0", m1_bus.ack, m0_bus.ack); end
    checks++; if (m1_bus.dat_r !== 32'h11223344) begin errors++; $display("FAIL cont_rdata got %h exp 11223344", m1_bus.dat_r); end
    step();
    idle_masters();
    step();
  endtask

  task automatic test_round_robin();
    int idle_cnt;
    int k;
    do_reset();
    mc = 2'b11; ms = 2'b11;
    for (int g = 0; g < 6; g++) begin
      k = g % 2;
      idle_cnt = 0;
      @(negedge clk);
      while (grant === 2'b00 && idle_cnt < 10) begin
        checks++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL rr_gap_cyc grant %0d got %b exp 0", g, s_bus.cyc); end
        idle_cnt++;
        @(negedge clk);
      end
      checks++; if (grant !== (k == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_order grant %0d got %b exp %b", g, grant, (k == 0 ? 2'b01 : 2'b10)); end
      if (g > 0) begin
        checks++; if (idle_cnt != 1) begin errors++; $display("FAIL rr_gap grant %0d got %0d idle cycles exp 1", g, idle_cnt); end
      end
      s_ack = 1'b1;
      step();
      mc[k] = 1'b0; ms[k] = 1'b0; s_ack = 1'b0;
      step();
      mc[k] = 1'b1; ms[k] = 1'b1;
    end
    idle_masters();
    step();
    step();
  endtask

  task automatic test_burst();
    int acks1 = 0;
    logic [DATA_W-1:0] rd;
    do_reset();
    mc[1] = 1'b1; ms[1] = 1'b1; madr[1] = 8'h00;
    step();
    @(negedge clk);
    mc[0] = 1'b1; ms[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++; if (grant !== 2'b10 || s_bus.adr !== ADDR_W'(i)) begin errors++; $display("FAIL burst_beat %0d got grant %b adr %h exp 10 %h", i, grant, s_bus.adr, i); end
      rd = $urandom;
      s_rdata = rd; s_ack = 1'b1;
      #1;
      checks++; if (m1_bus.ack !== 1'b1 || m0_bus.ack !== 1'b0 || m1_bus.dat_r !== rd) begin errors++; $display("FAIL burst_ack %0d got m1 %b m0 %b dat %h exp 1 0 %h", i, m1_bus.ack, m0_bus.ack, m1_bus.dat_r, rd); end
      if (m1_bus.ack === 1'b1) acks1++;
      step();
      madr[1] = ADDR_W'(i + 1);
    end
    mc[1] = 1'b0; ms[1] = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    checks++; if (grant === 2'b01) begin errors++; $display("FAIL burst_hold got %b exp not 01", grant); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL burst_idle got %b exp 00", grant); end
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL burst_next got %b exp 01", grant); end
    checks++; if (acks1 != 3) begin errors++; $display("FAIL burst_acks got %0d exp 3", acks1); end
    idle_masters();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mc[1] = 1'b1; ms[1] = 1'b1; madr[1] = 8'h07;
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b10 || s_bus.cyc !== 1'b1) begin errors++; $display("FAIL rmid_pre got grant %b cyc %b exp 10 1", grant, s_bus.cyc); end
    step();
    reset = 1'b1; s_ack = 1'b1;
    step();
    mc[0] = 1'b1; ms[0] = 1'b1;
    @(negedge clk);
    checks++; if (s_bus.cyc !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rmid_abort got cyc %b grant %b exp 0 00", s_bus.cyc, grant); end
    checks++; if (m1_bus.ack !== 1'b0 || m0_bus.ack !== 1'b0) begin errors++; $display("FAIL rmid_ack got m1 %b m0 %b exp 0 0", m1_bus.ack, m0_bus.ack); end
    step();
    reset = 1'b0; s_ack = 1'b0;
    step();
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_regrant got %b exp 01", grant); end
    idle_masters();
    step();
    step();
  endtask

  task automatic test_hold();
    int err_seen = 0;
    int limit;
`ifdef ARB_TIMEOUT_EN
    limit = 300;
`else
    limit = 100;
`endif
    do_reset();
    mc[0] = 1'b1; ms[0] = 1'b1; madr[0] = 8'h09;
    step();
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (m0_bus.err === 1'b1) err_seen++;
    end
`ifdef ARB_TIMEOUT_EN
    checks++; if (err_seen != 1) begin errors++; $display("FAIL hold_err got %0d pulses exp 1", err_seen); end
`else
    checks++; if (grant !== 2'b01 || s_bus.cyc !== 1'b1) begin errors++; $display("FAIL hold_grant got %b cyc %b exp 01 1", grant, s_bus.cyc); end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL hold_err got %0d pulses exp 0", err_seen); end
`endif
    idle_masters();
    step();
    step();
  endtask

  task automatic test_random();
    int owner = -1;
    bit last = 1'b1;
    logic [1:0]        eg;
    logic              ecyc;
    logic [ADDR_W-1:0] eadr;
    logic [DATA_W-1:0] edat;
    bit r0, r1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0) mc[k] = ~mc[k];
        ms[k] = 1'($urandom_range(0, 1));
        mw[k] = 1'($urandom_range(0, 1));
        msel[k] = 4'($urandom);
        madr[k] = ADDR_W'($urandom);
        mdat[k] = $urandom;
      end
      s_ack = 1'($urandom_range(0, 1));
      s_rdata = $urandom;
      @(negedge clk);
      eg   = (owner == 0) ? 2'b01 : ((owner == 1) ? 2'b10 : 2'b00);
      ecyc = (owner < 0) ? 1'b0 : mc[owner];
      eadr = (owner < 0) ? '0 : madr[owner];
      edat = (owner < 0) ? '0 : mdat[owner];
      checks++; if (grant !== eg) begin errors++; $display("FAIL rand_grant cyc %0d got %b exp %b", n, grant, eg); end
      checks++; if (s_bus.cyc !== ecyc || s_bus.adr !== eadr || s_bus.dat_w !== edat) begin errors++; $display("FAIL rand_mux cyc %0d got %b %h %h exp %b %h %h", n, s_bus.cyc, s_bus.adr, s_bus.dat_w, ecyc, eadr, edat); end
      checks++; if (m0_bus.ack !== (owner == 0 && s_ack) || m1_bus.ack !== (owner == 1 && s_ack)) begin errors++; $display("FAIL rand_ack cyc %0d got %b%b owner %0d ack %b", n, m1_bus.ack, m0_bus.ack, owner, s_ack); end
      checks++; if (m0_bus.dat_r !== s_rdata || m1_bus.dat_r !== s_rdata) begin errors++; $display("FAIL rand_rdata cyc %0d got %h %h exp %h", n, m0_bus.dat_r, m1_bus.dat_r, s_rdata); end
      r0 = mc[0] & ms[0];
      r1 = mc[1] & ms[1];
      if (owner < 0) begin
        if (r0 && r1) begin owner = last ? 0 : 1; last = (owner == 1); end
        else if (r0) begin owner = 0; last = 1'b0; end
        else if (r1) begin owner = 1; last = 1'b1; end
      end else if (!mc[owner]) begin
        owner = -1;
      end
      step();
    end
    idle_masters();
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_masters();
    test_reset();
    test_single_write();
    test_contention();
    test_round_robin();
    test_burst();
    test_reset_mid();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_wb_arbiter.md
Name: ram_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the shared pattern RAM.
- Master 0 is the host-side loader, which writes waveform words into RAM through Caravel.
- Master 1 is the function-generator RAMBus read port.
- Grants are round-robin. A grant is held for the whole bus cycle (cyc high). Slave signals are muxed from the granted master, and ack is routed back to that master only.

Parameters:
- ADDR_W, 8, width of RAM word address.
- DATA_W, 32, width of data buses.
- TIMEOUT, 255, cycles a grant may be held without slave ack before it is aborted. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
- m0_sel_i  in  4  master 0 byte select
- m0_adr_i  in  ADDR_W  master 0 address
- m0_dat_i  in  DATA_W  master 0 write data
- m0_ack_o  out  1  master 0 ack
- m0_err_o  out  1  master 0 timeout error
- m0_dat_o  out  DATA_W  master 0 read data
- m1_* : same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave controls
- s_sel_o  out  4  slave byte select
- s_adr_o  out  ADDR_W  slave address
- s_dat_o  out  DATA_W  slave write data
- s_ack_i  in  1  slave ack
- s_dat_i  in  DATA_W  slave read data
- grant_o  out  2  one-hot current grant, for debug; 00 when idle

Behaviour:
- Reset values: state IDLE, last_grant=1, so master 0 wins the first contention.
  - All s_* outputs are 0, s_sel_o=0.
  - m0/m1 ack and err are 0.
  - grant_o=00.
- FSM states: IDLE, GNT0, GNT1. The state register is the only sequential element besides last_grant and the optional timer.
- A master requests when cyc_i && stb_i.
- IDLE transitions:
  - Only m0 requests -> GNT0.
  - Only m1 requests -> GNT1.
  - Both request -> grant the master not equal to last_grant.
  - Neither requests -> stay in IDLE.
- last_grant updates on entry to GNTn.
- Latency: a grant is registered one cycle after the request is seen, so the slave sees stb no earlier than the cycle after the master raises stb.
- GNTn datapath: s_cyc/stb/we/sel/adr/dat are driven combinationally from master n.
  - mn_ack_o = s_ack_i. The other master's ack is 0.
  - m0_dat_o and m1_dat_o both carry s_dat_i. Masters must qualify the data with their own ack.
- GNTn exit: stay while mn_cyc_i is high, so multiple stb/ack beats within one cyc are allowed. When mn_cyc_i is low -> IDLE.
- There is one mandatory IDLE cycle between grants, so the slave always sees cyc low for at least 1 cycle between owners.
- In IDLE, all s_* outputs are 0. Any s_ack_i arriving in IDLE is dropped and not forwarded.
- Starvation bound: with both masters continuously requesting and releasing, grants alternate 0,1,0,1.
- Reset mid-cycle: on the clock edge where reset is sampled, state goes to IDLE. s_cyc_o and the acks are low from that edge. There is no completion of the in-flight transfer.
- A master that drops cyc without an ack (abort) returns the FSM to IDLE normally.
- grant_o reads 01 in GNT0 and 10 in GNT1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro: an 8-bit or wider counter clears on grant entry and on each s_ack_i. It increments every GNTn cycle without ack.
  - When it reaches TIMEOUT, mn_err_o pulses for 1 cycle, and the FSM goes to ABORT for 1 cycle with all s_* at 0.
  - In ABORT the granted master is ignored. The FSM then goes to IDLE only after mn_cyc_i is low.
  - last_grant is unchanged, so the other master is favoured next.
- Without the macro: m0_err_o and m1_err_o are tied to 0, there is no counter and no ABORT state, and a grant is held indefinitely.

Test Plan:
- Reset released, m0 writes adr=0x03 dat=0xA5A5A5A5 sel=1111 -> one cycle later s_stb_o=1 with those values; RAM ack -> m0_ack_o=1, m1_ack_o=0, grant_o=01 during the cycle.
- m0 and m1 assert requests on the same cycle -> GNT0 first; after m0 drops cyc, 1 idle cycle, then GNT1; m1 reads adr=0x00 and receives s_dat_i=0x11223344 with m1_ack_o.
- Both masters continuously re-request for 6 grants -> grant sequence 0,1,0,1,0,1 with s_cyc_o low for exactly 1 cycle between each.
- m1 holds cyc for a 3-beat burst (adr 0,1,2) while m0 requests -> m0 is not granted until m1 cyc falls; slave sees 3 acks, all routed to m1.
- Reset asserted while in GNT1 with stb high and no ack -> on the next edge s_cyc_o=0, grant_o=00; after release, a simultaneous request grants m0.
- ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks m0 -> m0_err_o pulses at grant cycle 16, s_cyc_o=0; m1 is granted after m0 drops cyc. Without the macro, the grant is still held at cycle 100.
